// File: rtl/icache_mem_ctrl.sv
// I-cache miss handler: MSHR table, imem request issue, tag binding and fill return.
// Optional next-line prefetch enabled by defining ICACHE_NEXT_LINE_PREFETCH_EN.
`ifndef XLEN
`define XLEN 32
`endif

module icache_mem_ctrl #(
  parameter int XLEN       = `XLEN,
  parameter int MSHR_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            miss_valid,
  input  logic [XLEN-1:0] miss_addr,
  output logic            miss_ready,
  output logic [XLEN-1:0] proc2mem_addr,
  output logic [1:0]      proc2mem_command,
  output logic [1:0]      proc2mem_size,
  output logic [63:0]     proc2mem_data,
  input  logic [3:0]      mem2proc_response,
  input  logic [63:0]     mem2proc_data,
  input  logic [3:0]      mem2proc_tag,
  output logic            fill_valid,
  output logic [XLEN-1:0] fill_addr,
  output logic [63:0]     fill_data,
  output logic            fill_prefetch
);

  localparam int IDX_W = $clog2(MSHR_DEPTH);
  localparam logic [1:0] BUS_NONE = 2'h0;
  localparam logic [1:0] BUS_LOAD = 2'h1;
  localparam logic [1:0] DOUBLE   = 2'h3;

  typedef enum logic [1:0] {
    ST_FREE = 2'd0,
    ST_PEND = 2'd1,
    ST_WAIT = 2'd2
  } ent_state_e;

  ent_state_e      state_r [MSHR_DEPTH];
  logic [XLEN-1:0] addr_r  [MSHR_DEPTH];
  logic [3:0]      tag_r   [MSHR_DEPTH];

  logic [XLEN-1:0]       miss_line_s;
  logic [MSHR_DEPTH-1:0] free_mask_s;
  logic [MSHR_DEPTH-1:0] pend_mask_s;
  logic [MSHR_DEPTH-1:0] dup_mask_s;
  logic [MSHR_DEPTH-1:0] fill_mask_s;
  logic [IDX_W:0]        free_sel_s;
  logic [IDX_W:0]        pend_sel_s;
  logic [IDX_W:0]        fill_sel_s;
  logic                  dup_s;
  logic                  alloc_s;
  logic                  grant_s;

  // Returns {found, index} of the lowest set bit of mask.
  function automatic logic [IDX_W:0] lowest_set(input logic [MSHR_DEPTH-1:0] mask);
    logic [IDX_W:0] res;
    res = '0;
    for (int i = MSHR_DEPTH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        res = {1'b1, IDX_W'(i)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign miss_line_s = miss_addr & ~XLEN'(7);

  // Per-entry status vectors derived from registered state.
  always_comb begin
    free_mask_s = '0;
    pend_mask_s = '0;
    dup_mask_s  = '0;
    fill_mask_s = '0;
    for (int i = 0; i < MSHR_DEPTH; i++) begin
      free_mask_s[i] = (state_r[i] == ST_FREE);
      pend_mask_s[i] = (state_r[i] == ST_PEND);
      dup_mask_s[i]  = (state_r[i] != ST_FREE) && (addr_r[i] == miss_line_s);
      fill_mask_s[i] = (state_r[i] == ST_WAIT) && (mem2proc_tag != 4'h0) &&
                       (tag_r[i] == mem2proc_tag);
    end
  end

  assign free_sel_s = lowest_set(free_mask_s);
  assign pend_sel_s = lowest_set(pend_mask_s);
  assign fill_sel_s = lowest_set(fill_mask_s);
  assign dup_s      = |dup_mask_s;
  assign miss_ready = free_sel_s[IDX_W] | dup_s;
  assign alloc_s    = miss_valid & ~dup_s & free_sel_s[IDX_W];
  assign grant_s    = pend_sel_s[IDX_W] & (mem2proc_response != 4'h0);

  // The request is a pure decode of the table so a grant lands on the entry it names.
  assign proc2mem_command = pend_sel_s[IDX_W] ? BUS_LOAD : BUS_NONE;
  assign proc2mem_addr    = pend_sel_s[IDX_W] ? addr_r[pend_sel_s[IDX_W-1:0]] : '0;
  assign proc2mem_size    = DOUBLE;
  assign proc2mem_data    = 64'h0;

`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
  logic                  pf_r [MSHR_DEPTH];
  logic [XLEN-1:0]       pf_line_s;
  logic [MSHR_DEPTH-1:0] pf_dup_mask_s;
  logic [IDX_W:0]        free2_sel_s;
  logic                  pf_carry_s;
  logic                  pf_alloc_s;

  assign pf_line_s   = miss_line_s + XLEN'(8);
  assign pf_carry_s  = &miss_line_s[XLEN-1:3];
  assign free2_sel_s = lowest_set(free_mask_s &
                       ~(MSHR_DEPTH'(1) << free_sel_s[IDX_W-1:0]));

  // Entries already holding the next line suppress the prefetch.
  always_comb begin
    pf_dup_mask_s = '0;
    for (int i = 0; i < MSHR_DEPTH; i++) begin
      pf_dup_mask_s[i] = (state_r[i] != ST_FREE) && (addr_r[i] == pf_line_s);
    end
  end

  assign pf_alloc_s = alloc_s & free2_sel_s[IDX_W] & ~pf_carry_s & ~(|pf_dup_mask_s);

  // Prefetch flag per entry, captured on allocation.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MSHR_DEPTH; i++) begin
        pf_r[i] <= 1'b0;
      end
    end else begin
      if (alloc_s) begin
        pf_r[free_sel_s[IDX_W-1:0]] <= 1'b0;
      end
      if (pf_alloc_s) begin
        pf_r[free2_sel_s[IDX_W-1:0]] <= 1'b1;
      end
    end
  end
`endif

  // MSHR entry state machine plus the registered fill outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MSHR_DEPTH; i++) begin
        state_r[i] <= ST_FREE;
        addr_r[i]  <= '0;
        tag_r[i]   <= 4'h0;
      end
      fill_valid    <= 1'b0;
      fill_addr     <= '0;
      fill_data     <= 64'h0;
      fill_prefetch <= 1'b0;
    end else begin
      if (grant_s) begin
        state_r[pend_sel_s[IDX_W-1:0]] <= ST_WAIT;
        tag_r[pend_sel_s[IDX_W-1:0]]   <= mem2proc_response;
      end
      if (fill_sel_s[IDX_W]) begin
        state_r[fill_sel_s[IDX_W-1:0]] <= ST_FREE;
        fill_valid <= 1'b1;
        fill_addr  <= addr_r[fill_sel_s[IDX_W-1:0]];
        fill_data  <= mem2proc_data;
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
        fill_prefetch <= pf_r[fill_sel_s[IDX_W-1:0]];
`else
        fill_prefetch <= 1'b0;
`endif
      end else begin
        fill_valid <= 1'b0;
      end
      // Allocation only targets entries FREE at the start of the cycle.
      if (alloc_s) begin
        state_r[free_sel_s[IDX_W-1:0]] <= ST_PEND;
        addr_r[free_sel_s[IDX_W-1:0]]  <= miss_line_s;
      end
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
      if (pf_alloc_s) begin
        state_r[free2_sel_s[IDX_W-1:0]] <= ST_PEND;
        addr_r[free2_sel_s[IDX_W-1:0]]  <= pf_line_s;
      end
`endif
    end
  end

endmodule

// File: tb/tb_icache_mem_ctrl.sv
// Scoreboard bench for icache_mem_ctrl with a behavioural tagged imem model.
module tb_icache_mem_ctrl;

  localparam logic [1:0] BUS_NONE = 2'h0;
  localparam logic [1:0] BUS_LOAD = 2'h1;
  localparam logic [1:0] DOUBLE   = 2'h3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_valid = 1'b0;
  logic [31:0] miss_addr = 32'h0;
  logic        miss_ready;
  logic [31:0] proc2mem_addr;
  logic [1:0]  proc2mem_command;
  logic [1:0]  proc2mem_size;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_response;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_tag;
  logic        fill_valid;
  logic [31:0] fill_addr;
  logic [63:0] fill_data;
  logic        fill_prefetch;

  icache_mem_ctrl #(.XLEN(32), .MSHR_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_ready(miss_ready),
    .proc2mem_addr(proc2mem_addr), .proc2mem_command(proc2mem_command),
    .proc2mem_size(proc2mem_size), .proc2mem_data(proc2mem_data),
    .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
    .mem2proc_tag(mem2proc_tag),
    .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_data(fill_data),
    .fill_prefetch(fill_prefetch)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [63:0] data;
    logic        pf;
  } exp_t;

  typedef struct packed {
    int          due;
    logic [3:0]  tag;
    logic [31:0] addr;
  } ret_t;

  exp_t exp_q[$];
  ret_t ret_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   lat = 3;
  int   reject_cnt = 0;
  int   req_cnt = 0;
  int   fill_cnt = 0;
  logic [3:0] next_tag = 4'h1;

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {a ^ 32'hA5A5_0000, ~a};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // imem model: grants or rejects on negedge, returns data lat cycles after a grant.
  initial begin
    ret_t r;
    mem2proc_response = 4'h0;
    mem2proc_tag      = 4'h0;
    mem2proc_data     = 64'h0;
    forever begin
      @(negedge clk);
      if (proc2mem_command === BUS_LOAD) begin
        req_cnt++;
        if (reject_cnt > 0) begin
          reject_cnt--;
          mem2proc_response = 4'h0;
        end else begin
          ret_q.push_back('{due: cyc + lat, tag: next_tag, addr: proc2mem_addr});
          mem2proc_response = next_tag;
          next_tag = (next_tag == 4'hF) ? 4'h1 : next_tag + 4'h1;
        end
      end else begin
        mem2proc_response = 4'h0;
      end
      if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
        r = ret_q.pop_front();
        mem2proc_tag  = r.tag;
        mem2proc_data = mem_word(r.addr);
      end else begin
        mem2proc_tag  = 4'h0;
        mem2proc_data = 64'h0;
      end
    end
  end

  // Fill scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (fill_valid === 1'b1) begin
        fill_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL fill_unexpected got addr=%h data=%h pf=%b expected none",
                   fill_addr, fill_data, fill_prefetch);
        end else begin
          e = exp_q.pop_front();
          if (fill_addr !== e.addr || fill_data !== e.data || fill_prefetch !== e.pf) begin
            errors++;
            $display("FAIL fill got addr=%h data=%h pf=%b expected addr=%h data=%h pf=%b",
                     fill_addr, fill_data, fill_prefetch, e.addr, e.data, e.pf);
          end
        end
      end
    end
  end

  // Called #1 after a posedge; returns #1 after the accepting posedge.
  task automatic send_miss(input logic [31:0] a, input bit expect_fill);
    int n;
    logic [31:0] line;
    line = a & 32'hFFFF_FFF8;
    miss_valid = 1'b1;
    miss_addr  = a;
    n = 0;
    @(negedge clk);
    while (miss_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (miss_ready !== 1'b1) begin
      errors++;
      $display("FAIL miss_accept addr=%h got ready=%b expected 1", a, miss_ready);
    end
    @(posedge clk);
    #1;
    miss_valid = 1'b0;
    if (expect_fill) begin
      exp_q.push_back('{addr: line, data: mem_word(line), pf: 1'b0});
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
      if (line != 32'hFFFF_FFF8)
        exp_q.push_back('{addr: line + 32'd8, data: mem_word(line + 32'd8), pf: 1'b1});
`endif
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || ret_q.size() != 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d fills pending expected 0", exp_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks += 6;
    if (proc2mem_command !== BUS_NONE || proc2mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_req got cmd=%h addr=%h expected 0 0", proc2mem_command, proc2mem_addr);
    end
    if (proc2mem_size !== DOUBLE) begin
      errors++;
      $display("FAIL reset_size got %h expected %h", proc2mem_size, DOUBLE);
    end
    if (proc2mem_data !== 64'h0) begin
      errors++;
      $display("FAIL reset_data got %h expected 0", proc2mem_data);
    end
    if (fill_valid !== 1'b0 || fill_prefetch !== 1'b0) begin
      errors++;
      $display("FAIL reset_fill got v=%b pf=%b expected 0 0", fill_valid, fill_prefetch);
    end
    if (fill_addr !== 32'h0 || fill_data !== 64'h0) begin
      errors++;
      $display("FAIL reset_fill_bus got %h %h expected 0 0", fill_addr, fill_data);
    end
    if (miss_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b expected 1", miss_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    send_miss(32'h0000_0103, 1'b1);
    @(negedge clk);
    checks++;
    if (proc2mem_command !== BUS_LOAD || proc2mem_addr !== 32'h100) begin
      errors++;
      $display("FAIL single_req got cmd=%h addr=%h expected 1 100", proc2mem_command, proc2mem_addr);
    end
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic test_reject();
    reject_cnt = 3;
    send_miss(32'h200, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (proc2mem_command !== BUS_LOAD || proc2mem_addr !== 32'h200) begin
        errors++;
        $display("FAIL reject_retry%0d got cmd=%h addr=%h expected 1 200",
                 k, proc2mem_command, proc2mem_addr);
      end
    end
`ifndef ICACHE_NEXT_LINE_PREFETCH_EN
    @(negedge clk);
    checks++;
    if (proc2mem_command !== BUS_NONE) begin
      errors++;
      $display("FAIL reject_after_grant got cmd=%h expected 0", proc2mem_command);
    end
`endif
    @(posedge clk);
    #1;
    drain();
  endtask

`ifndef ICACHE_NEXT_LINE_PREFETCH_EN
  task automatic test_back_to_back();
    int n;
    lat = 4;
    send_miss(32'h00, 1'b1);
    send_miss(32'h08, 1'b1);
    send_miss(32'h10, 1'b1);
    send_miss(32'h18, 1'b1);
    miss_valid = 1'b1;
    miss_addr  = 32'h20;
    @(negedge clk);
    checks++;
    if (miss_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready got %b expected 0", miss_ready);
    end
    n = 0;
    while (miss_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (miss_ready !== 1'b1 || fill_valid !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_fill got ready=%b fill=%b expected 1 1", miss_ready, fill_valid);
    end
    @(posedge clk);
    #1;
    miss_valid = 1'b0;
    exp_q.push_back('{addr: 32'h20, data: mem_word(32'h20), pf: 1'b0});
    drain();
    lat = 3;
  endtask
`endif

  task automatic test_duplicate();
    int r0;
    int f0;
    lat = 6;
    r0 = req_cnt;
    f0 = fill_cnt;
    send_miss(32'h40, 1'b1);
    @(posedge clk);
    #1;
    send_miss(32'h44, 1'b0);
    drain();
    checks += 2;
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
    if (req_cnt - r0 != 2) begin
`else
    if (req_cnt - r0 != 1) begin
`endif
      errors++;
      $display("FAIL dup_requests got %0d", req_cnt - r0);
    end
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
    if (fill_cnt - f0 != 2) begin
`else
    if (fill_cnt - f0 != 1) begin
`endif
      errors++;
      $display("FAIL dup_fills got %0d", fill_cnt - f0);
    end
    lat = 3;
  endtask

  task automatic test_reset_flush();
    int f0;
    lat = 8;
    f0 = fill_cnt;
    send_miss(32'h300, 1'b0);
    send_miss(32'h400, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (proc2mem_command !== BUS_NONE || proc2mem_addr !== 32'h0 || fill_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_outputs got cmd=%h addr=%h fill=%b expected 0 0 0",
               proc2mem_command, proc2mem_addr, fill_valid);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (fill_cnt != f0) begin
      errors++;
      $display("FAIL flush_stale_fill got %0d fills expected 0", fill_cnt - f0);
    end
    lat = 3;
  endtask

`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
  task automatic test_prefetch();
    int r0;
    send_miss(32'h100, 1'b1);
    @(negedge clk);
    checks++;
    if (proc2mem_command !== BUS_LOAD || proc2mem_addr !== 32'h100) begin
      errors++;
      $display("FAIL pf_req0 got cmd=%h addr=%h expected 1 100", proc2mem_command, proc2mem_addr);
    end
    @(negedge clk);
    checks++;
    if (proc2mem_command !== BUS_LOAD || proc2mem_addr !== 32'h108) begin
      errors++;
      $display("FAIL pf_req1 got cmd=%h addr=%h expected 1 108", proc2mem_command, proc2mem_addr);
    end
    @(posedge clk);
    #1;
    drain();
    r0 = req_cnt;
    send_miss(32'hFFFF_FFF8, 1'b1);
    drain();
    checks++;
    if (req_cnt - r0 != 1) begin
      errors++;
      $display("FAIL pf_carry got %0d requests expected 1", req_cnt - r0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_reject();
`ifndef ICACHE_NEXT_LINE_PREFETCH_EN
    test_back_to_back();
`endif
    test_duplicate();
    test_reset_flush();
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
    test_prefetch();
`endif
    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1);
  end

endmodule
